// File: rtl/run_length_mealy.sv
// Run-length tracker for a qualified serial bit stream with a same-cycle (Mealy) length output.
// Optional run-end reporting is compiled in when RUN_END_REPORT_EN is defined.
module run_length_mealy #(
    parameter int CNT_W   = 4,
    parameter int SAT_MAX = 15,
    parameter int THRESH  = 3
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic             clr,
    input  logic             bit_vld,
    input  logic             bit_in,
    input  logic             match_val,
    output logic [CNT_W-1:0] result,
    output logic             hit,
    output logic [CNT_W-1:0] run_q,
    output logic [CNT_W-1:0] max_run
`ifdef RUN_END_REPORT_EN
    ,
    output logic             run_end,
    output logic [CNT_W-1:0] run_end_len
`endif
);

    localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT_MAX);
    localparam logic [CNT_W-1:0] THR_V = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

    // bit_vld is a one-way qualifier: there is no ready, and every cycle with
    // bit_vld=1 consumes bit_in. Cycles with bit_vld=0 leave the run intact.
    logic             match;
    logic [CNT_W-1:0] nxt;

    always_comb begin
        match  = bit_vld & (bit_in == match_val);
        nxt    = (run_q == SAT_V) ? SAT_V : run_q + ONE_V;
        result = '0;
        if (!rst_p && !clr && match) begin
            result = nxt;
        end
        hit = (result >= THR_V);
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            run_q   <= '0;
            max_run <= '0;
        end else if (clr) begin
            run_q   <= '0;
            max_run <= '0;
        end else if (bit_vld) begin
            if (match) begin
                run_q <= nxt;
                if (nxt > max_run) begin
                    max_run <= nxt;
                end
            end else begin
                run_q <= '0;
            end
        end
    end

`ifdef RUN_END_REPORT_EN
    // A mismatch ending a non-empty run reports that run's (saturated) length next cycle.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            run_end     <= 1'b0;
            run_end_len <= '0;
        end else if (clr) begin
            run_end <= 1'b0;
        end else if (bit_vld && !match && (run_q != '0)) begin
            run_end     <= 1'b1;
            run_end_len <= run_q;
        end else begin
            run_end <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_run_length_mealy.sv
// Randomized and directed bench for run_length_mealy against a count-based reference model.
// Define RUN_END_REPORT_EN at compile time to also check the run-end report outputs.
module tb_run_length_mealy;

    localparam int CNT_W   = 4;
    localparam int SAT_MAX = 15;
    localparam int THRESH  = 3;

    logic clk;
    logic rst_p, clr, bit_vld, bit_in, match_val;

    logic [CNT_W-1:0] result, run_q, max_run;
    logic             hit;
    logic [1:0]       l_result, l_run_q, l_max_run;
    logic             l_hit;
`ifdef RUN_END_REPORT_EN
    logic             run_end, l_run_end;
    logic [CNT_W-1:0] run_end_len;
    logic [1:0]       l_run_end_len;
`endif

    run_length_mealy #(.CNT_W(CNT_W), .SAT_MAX(SAT_MAX), .THRESH(THRESH)) dut (
        .clk(clk), .rst_p(rst_p), .clr(clr), .bit_vld(bit_vld), .bit_in(bit_in),
        .match_val(match_val), .result(result), .hit(hit), .run_q(run_q), .max_run(max_run)
`ifdef RUN_END_REPORT_EN
        , .run_end(run_end), .run_end_len(run_end_len)
`endif
    );

    run_length_mealy #(.CNT_W(2), .SAT_MAX(3), .THRESH(3)) dut_legacy (
        .clk(clk), .rst_p(rst_p), .clr(clr), .bit_vld(bit_vld), .bit_in(bit_in),
        .match_val(match_val), .result(l_result), .hit(l_hit), .run_q(l_run_q),
        .max_run(l_max_run)
`ifdef RUN_END_REPORT_EN
        , .run_end(l_run_end), .run_end_len(l_run_end_len)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard counters and reference model state
    int n_tests = 0;
    int n_fail  = 0;
    int run_len = 0;     // unbounded count of consecutive matches
    int max_len = 0;     // longest saturated run seen
    int exp_res = 0;
    int exp_end = 0;
    int exp_end_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    // drive inputs away from the active edge, then check the Mealy outputs
    task automatic drive(input logic r, input logic c, input logic v, input logic b, input logic m);
        @(negedge clk);
        rst_p = r; clr = c; bit_vld = v; bit_in = b; match_val = m;
        #1;
        exp_res = (r || c || !v || (b != m)) ? 0 : sat(run_len + 1);
        check("result", result, exp_res);
        check("hit", hit, exp_res >= THRESH);
    endtask

    // take the edge, advance the model, check the registered outputs
    task automatic tick();
        @(posedge clk);
        if (rst_p) begin
            run_len = 0; max_len = 0; exp_end = 0; exp_end_len = 0;
        end else if (clr) begin
            run_len = 0; max_len = 0; exp_end = 0;
        end else if (bit_vld && bit_in == match_val) begin
            run_len++;
            if (sat(run_len) > max_len) max_len = sat(run_len);
            exp_end = 0;
        end else if (bit_vld) begin
            exp_end = (run_len > 0);
            if (run_len > 0) exp_end_len = sat(run_len);
            run_len = 0;
        end else begin
            exp_end = 0;
        end
        #1;
        check("run_q", run_q, sat(run_len));
        check("max_run", max_run, max_len);
`ifdef RUN_END_REPORT_EN
        check("run_end", run_end, exp_end);
        check("run_end_len", run_end_len, exp_end_len);
`endif
    endtask

    task automatic step(input logic r, input logic c, input logic v, input logic b, input logic m);
        drive(r, c, v, b, m);
        tick();
    endtask

    logic [1:0] leg_res[5];
    logic [1:0] leg_run[5];
    logic       leg_hit[5];
    logic       leg_bit[5];

    initial begin
        rst_p = 1'b1; clr = 1'b0; bit_vld = 1'b0; bit_in = 1'b0; match_val = 1'b1;
        step(1, 0, 1, 1, 1);
        check("reset_run_q", run_q, 0);
        check("reset_max_run", max_run, 0);

        // legacy 2-bit detector equivalence
        leg_bit = '{1, 1, 1, 1, 0};
        leg_res = '{1, 2, 3, 3, 0};
        leg_hit = '{0, 0, 1, 1, 0};
        leg_run = '{1, 2, 3, 3, 0};
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, leg_bit[i], 1);
            check("legacy_result", l_result, leg_res[i]);
            check("legacy_hit", l_hit, leg_hit[i]);
            tick();
            check("legacy_run_q", l_run_q, leg_run[i]);
        end

        // saturation on runs of zeros, then a mismatch keeps the record
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
        check("sat_max_run", max_run, 15);
        drive(0, 0, 1, 1, 0);
        check("sat_break_result", result, 0);
        tick();
        check("sat_break_max", max_run, 15);

        // gaps do not break a run
        step(0, 1, 0, 0, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        check("gap_run_q", run_q, 2);
        drive(0, 0, 1, 1, 1);
        check("gap_result", result, 3);
        check("gap_hit", hit, 1);
        tick();

        // clr with a simultaneous match at run_q=5
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1);
        drive(0, 1, 1, 1, 1);
        check("clr_result", result, 0);
        tick();
        step(0, 0, 1, 1, 1);

        // reset mid-run (run_q=7, max_run=9), then release without an edge
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 1);
        check("pre_rst_max", max_run, 9);
        step(1, 0, 1, 1, 1);
        drive(0, 0, 0, 1, 1);
        check("rst_release_run_q", run_q, 0);
        tick();

        // run-end report: 1,1,1,1,0 then 0, then clr during a run of 2
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        step(0, 1, 1, 0, 1);
        step(0, 0, 1, 0, 1);

        // randomized stimulus biased toward long runs
        for (int i = 0; i < 600; i++) begin
            logic r, c, v, b, m;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 3);
            v = ($urandom_range(0, 99) < 80);
            m = (i % 150 < 75);
            b = ($urandom_range(0, 99) < 85) ? m : ~m;
            step(r, c, v, b, m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/run_length_mealy.md
Name: run_length_mealy

Overview:
- Parametrised successor to the 2-bit "count consecutive ones" Mealy detector.
- Tracks the length of the current run of consecutive matching bits on a qualified serial input.
- Reports the run length combinationally in the same cycle (Mealy), saturating at a configurable ceiling, plus a threshold hit flag and a longest-run record.
- Sits behind serial line monitors (bit-stuffing, idle/break detection) in the serial datapath.

Parameters:
- CNT_W, 4: width of run counter and all length outputs; legal range >= 2.
- SAT_MAX, 15: saturation ceiling for the run length; 1 <= SAT_MAX <= 2^CNT_W-1.
- THRESH, 3: run length at which hit asserts; 1 <= THRESH <= SAT_MAX.

Ports:
- clk  in  1  rising-edge clock.
- rst_p  in  1  synchronous active-high reset.
- clr  in  1  synchronous clear of run and record state.
- bit_vld  in  1  qualifies bit_in this cycle.
- bit_in  in  1  serial data bit.
- match_val  in  1  bit value being counted (1 = runs of ones, 0 = runs of zeros).
- result  out  CNT_W  Mealy run length including the current bit.
- hit  out  1  Mealy, result >= THRESH.
- run_q  out  CNT_W  registered run length (state).
- max_run  out  CNT_W  registered longest run since reset/clr.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst_p). Reset is sampled only on rising clk, has no asynchronous path, and overrides everything.
- On rst_p=1 at the edge: run_q=0, max_run=0. Combinational outputs follow from state and inputs; result=0 and hit=0 while rst_p=1.
- Define match = bit_vld & (bit_in == match_val), and nxt = (run_q == SAT_MAX) ? SAT_MAX : run_q+1.
- Priority (highest first): rst_p, clr, bit_vld.
- clr=1 (rst_p=0):
  - next run_q=0, next max_run=0.
  - result=0, hit=0; the input bit that cycle is discarded.
- bit_vld=1 and match:
  - result = nxt, run_q <= nxt.
  - max_run <= max(max_run, nxt).
- bit_vld=1 and mismatch: result=0, run_q <= 0, max_run unchanged.
- bit_vld=0: result=0, hit=0, run_q and max_run hold. A gap does not break a run.
- hit = (result >= THRESH), purely combinational. There is no registered latency on result or hit; registered outputs update one edge later.
- Saturation: run_q never exceeds SAT_MAX and never wraps. Further matches hold it at SAT_MAX with result=SAT_MAX.
- match_val changes have no implicit clear. The compare uses the new value against the existing run_q. Callers pulse clr when switching mode.
- Comparisons are unsigned, at CNT_W bits. There is no overflow path because SAT_MAX <= 2^CNT_W-1.
- Equivalence check: with CNT_W=2, SAT_MAX=3, THRESH=3, bit_vld=1, match_val=1, the result sequence equals the legacy 2-bit detector.

Optional Feature:
- Macro: RUN_END_REPORT_EN.
- When defined, two extra registered outputs exist:
  - run_end (1 bit).
  - run_end_len (CNT_W bits).
- Trigger: a cycle with bit_vld=1, mismatch, run_q>=1, clr=0 and rst_p=0.
- Response on the next cycle: run_end=1 for exactly one cycle; run_end_len=run_q from the trigger cycle (saturated value).
- run_end_len holds until the next report.
- Reset clears both outputs to 0. clr clears run_end and suppresses the report for the run being cleared.
- When the macro is undefined, the ports and logic are absent; core behaviour is identical.

Test Plan:
- Legacy mode (CNT_W=2, SAT_MAX=3, THRESH=3, match_val=1, bit_vld=1), bit_in 1,1,1,1,0 -> result 1,2,3,3,0; hit 0,0,1,1,0; run_q after each edge 1,2,3,3,0.
- Defaults, match_val=0, 20 consecutive valid zeros -> result climbs 1..15 then holds 15 for 5 cycles; max_run=15; one valid 1 -> result=0, run_q=0, max_run stays 15.
- Gaps: valid 1,1, then bit_vld=0 for 3 cycles (result=0, run_q=2 held), then valid 1 -> result=3, hit=1.
- Simultaneous clr and valid match with run_q=5 -> result=0 that cycle; next cycle run_q=0, max_run=0; following valid 1 -> result=1.
- rst_p asserted mid-run (run_q=7, max_run=9), with bit_vld=1 and bit_in=1 -> result=0, hit=0; after edge run_q=0, max_run=0. Deassert rst_p without a clock edge -> state unchanged (synchronous).
- RUN_END_REPORT_EN defined: valid 1,1,1,1, then valid 0 -> next cycle run_end=1, run_end_len=4; a further valid 0 -> no pulse; clr during a run of 2 -> no pulse.
